// File: rtl/imm_decode_stage.sv
// Registered immediate decoder for RV32/RV64 with a valid/ready pipeline slot, stall and flush.
// Define IMM_DECODE_CSR_EN to accept SYSTEM (CSR) immediates; otherwise that opcode is illegal.
package HighLevelControl;
    typedef enum logic [2:0] {Imm11t0, Imm4t0, SType, BType, UType, JType} immSrc;
endpackage

module imm_decode_stage
    import HighLevelControl::*;
#(
    parameter int unsigned BIT_COUNT  = 32,
    parameter int unsigned SHAMT_BITS = $clog2(BIT_COUNT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Flush,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [31:0]          Instr,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [BIT_COUNT-1:0] Imm,
    output immSrc                ImmType,
    output logic                 HasImm,
    output logic                 Illegal
);

    localparam bit IS_RV64 = (BIT_COUNT == 64);

    generate
        if (BIT_COUNT != 32 && BIT_COUNT != 64) begin : g_bad_width
            $error("imm_decode_stage: BIT_COUNT must be 32 or 64");
        end
        if (SHAMT_BITS != $clog2(BIT_COUNT)) begin : g_bad_shamt
            $error("imm_decode_stage: SHAMT_BITS is derived from BIT_COUNT");
        end
    endgenerate

    logic       accept;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_shift;

    assign InReady  = !OutValid || OutReady;
    assign accept   = InValid && InReady && !Flush;
    assign opcode   = Instr[6:0];
    assign funct3   = Instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Candidate immediates for every format; the decoder just picks one.
    logic [BIT_COUNT-1:0] i_imm, s_imm, b_imm, u_imm, j_imm, shamt_imm, shamt5_imm;

    assign i_imm      = BIT_COUNT'($signed(Instr[31:20]));
    assign s_imm      = BIT_COUNT'($signed({Instr[31:25], Instr[11:7]}));
    assign b_imm      = BIT_COUNT'($signed({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0}));
    assign u_imm      = BIT_COUNT'($signed({Instr[31:12], 12'b0}));
    assign j_imm      = BIT_COUNT'($signed({Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0}));
    assign shamt_imm  = BIT_COUNT'(Instr[20 +: SHAMT_BITS]);
    assign shamt5_imm = BIT_COUNT'(Instr[24:20]);

`ifdef IMM_DECODE_CSR_EN
    logic [BIT_COUNT-1:0] csr_uimm, csr_addr;
    assign csr_uimm = BIT_COUNT'(Instr[19:15]);
    assign csr_addr = BIT_COUNT'(Instr[31:20]);
`endif

    logic [BIT_COUNT-1:0] dec_imm;
    immSrc                dec_type;
    logic                 dec_has;
    logic                 dec_illegal;

    // Opcode-driven format selection; illegal encodings leave imm/type at their defaults.
    always_comb begin
        dec_imm     = '0;
        dec_type    = Imm11t0;
        dec_has     = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0000011, 7'b1100111: begin
                dec_imm = i_imm;
                dec_has = 1'b1;
            end
            7'b0010011: begin
                if (!is_shift) begin
                    dec_imm = i_imm;
                    dec_has = 1'b1;
                end else if (!IS_RV64 && Instr[25]) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_imm  = shamt_imm;
                    dec_type = Imm4t0;
                    dec_has  = 1'b1;
                end
            end
            7'b0011011: begin
                if (!IS_RV64) begin
                    dec_illegal = 1'b1;
                end else if (is_shift) begin
                    dec_imm  = shamt5_imm;
                    dec_type = Imm4t0;
                    dec_has  = 1'b1;
                end else begin
                    dec_imm = i_imm;
                    dec_has = 1'b1;
                end
            end
            7'b0100011: begin
                dec_imm  = s_imm;
                dec_type = SType;
                dec_has  = 1'b1;
            end
            7'b1100011: begin
                dec_imm  = b_imm;
                dec_type = BType;
                dec_has  = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm  = u_imm;
                dec_type = UType;
                dec_has  = 1'b1;
            end
            7'b1101111: begin
                dec_imm  = j_imm;
                dec_type = JType;
                dec_has  = 1'b1;
            end
            7'b0110011: begin
                dec_has = 1'b0;
            end
            7'b0111011: begin
                dec_illegal = !IS_RV64;
            end
`ifdef IMM_DECODE_CSR_EN
            7'b1110011: begin
                dec_has = 1'b1;
                if (funct3 >= 3'b101) begin
                    dec_imm  = csr_uimm;
                    dec_type = Imm4t0;
                end else begin
                    dec_imm = csr_addr;
                end
            end
`endif
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Single pipeline slot; flush drops the held entry and blocks the incoming one.
    always_ff @(posedge clk) begin
        if (reset) begin
            OutValid <= 1'b0;
            Imm      <= '0;
            ImmType  <= Imm11t0;
            HasImm   <= 1'b0;
            Illegal  <= 1'b0;
        end else if (Flush) begin
            OutValid <= 1'b0;
        end else if (accept) begin
            OutValid <= 1'b1;
            Imm      <= dec_imm;
            ImmType  <= dec_type;
            HasImm   <= dec_has;
            Illegal  <= dec_illegal;
        end else if (OutReady) begin
            OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench: RV64 and RV32 instances share stimulus; a queue model of the slot
// holds expected decodes computed arithmetically from the instruction fields.
module tb_imm_decode_stage;
    import HighLevelControl::*;

    typedef struct packed {
        logic [63:0] imm;
        immSrc       typ;
        logic        has;
        logic        ill;
    } exp_t;

    typedef struct packed {
        exp_t r64;
        exp_t r32;
    } pair_t;

    typedef struct packed {
        logic        iv;
        logic [31:0] w;
        logic        ordy;
        logic        fl;
        logic        rs;
    } step_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        out_ready = 1'b1;

    logic        ov64, ir64, hi64, il64;
    logic [63:0] imm64;
    immSrc       ty64;
    logic        ov32, ir32, hi32, il32;
    logic [31:0] imm32;
    immSrc       ty32;

    int total = 0;
    int bad = 0;

    pair_t sb[$];
    logic  started = 1'b0;
    logic  rst_state = 1'b0;

    always #5 clk = ~clk;

    imm_decode_stage #(.BIT_COUNT(64)) dut64 (
        .clk(clk), .reset(reset), .Flush(flush), .InValid(in_valid), .InReady(ir64),
        .Instr(instr), .OutValid(ov64), .OutReady(out_ready), .Imm(imm64),
        .ImmType(ty64), .HasImm(hi64), .Illegal(il64)
    );

    imm_decode_stage #(.BIT_COUNT(32)) dut32 (
        .clk(clk), .reset(reset), .Flush(flush), .InValid(in_valid), .InReady(ir32),
        .Instr(instr), .OutValid(ov32), .OutReady(out_ready), .Imm(imm32),
        .ImmType(ty32), .HasImm(hi32), .Illegal(il32)
    );

    function automatic logic [63:0] fld(input logic [31:0] w, input int hi, input int lo);
        logic [63:0] x;
        x = 64'(w) >> lo;
        return x & ((64'd1 << (hi - lo + 1)) - 64'd1);
    endfunction

    function automatic logic [63:0] fit(input logic [63:0] v, input int bc);
        return (bc == 32) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
    endfunction

    // Two's-complement value of an n-bit field, truncated to the datapath width.
    function automatic logic [63:0] sext(input logic [63:0] v, input int n, input int bc);
        logic [63:0] r;
        r = (v >= (64'd1 << (n - 1))) ? v - (64'd1 << n) : v;
        return fit(r, bc);
    endfunction

    function automatic exp_t model(input logic [31:0] w, input int bc);
        exp_t        r;
        logic [63:0] op, f3, v;
        logic        rv64, sh;
        rv64 = (bc == 64);
        op = fld(w, 6, 0);
        f3 = fld(w, 14, 12);
        sh = (f3 == 64'd1) || (f3 == 64'd5);
        r.imm = 64'd0;
        r.typ = Imm11t0;
        r.has = 1'b0;
        r.ill = 1'b0;
        case (op)
            64'h03, 64'h67: begin
                r.imm = sext(fld(w, 31, 20), 12, bc); r.has = 1'b1;
            end
            64'h13: begin
                if (!sh) begin
                    r.imm = sext(fld(w, 31, 20), 12, bc); r.has = 1'b1;
                end else if (!rv64 && fld(w, 25, 25) != 64'd0) begin
                    r.ill = 1'b1;
                end else begin
                    r.imm = fld(w, rv64 ? 25 : 24, 20); r.typ = Imm4t0; r.has = 1'b1;
                end
            end
            64'h1B: begin
                if (!rv64) r.ill = 1'b1;
                else if (sh) begin
                    r.imm = fld(w, 24, 20); r.typ = Imm4t0; r.has = 1'b1;
                end else begin
                    r.imm = sext(fld(w, 31, 20), 12, bc); r.has = 1'b1;
                end
            end
            64'h23: begin
                v = fld(w, 31, 25) * 32 + fld(w, 11, 7);
                r.imm = sext(v, 12, bc); r.typ = SType; r.has = 1'b1;
            end
            64'h63: begin
                v = fld(w, 31, 31) * 4096 + fld(w, 7, 7) * 2048 + fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2;
                r.imm = sext(v, 13, bc); r.typ = BType; r.has = 1'b1;
            end
            64'h37, 64'h17: begin
                r.imm = sext(fld(w, 31, 12) * 4096, 32, bc); r.typ = UType; r.has = 1'b1;
            end
            64'h6F: begin
                v = fld(w, 31, 31) * (64'd1 << 20) + fld(w, 19, 12) * 4096 + fld(w, 20, 20) * 2048 + fld(w, 30, 21) * 2;
                r.imm = sext(v, 21, bc); r.typ = JType; r.has = 1'b1;
            end
            64'h33: r.has = 1'b0;
            64'h3B: r.ill = !rv64;
`ifdef IMM_DECODE_CSR_EN
            64'h73: begin
                r.has = 1'b1;
                if (f3 >= 64'd5) begin
                    r.imm = fld(w, 19, 15); r.typ = Imm4t0;
                end else begin
                    r.imm = fld(w, 31, 20);
                end
            end
`endif
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Slot model: the queue is the pipeline content, updated on every active edge.
    always @(posedge clk) begin
        logic acc;
        if (reset) begin
            sb.delete();
            rst_state = 1'b1;
            started = 1'b1;
        end else if (flush) begin
            sb.delete();
        end else begin
            acc = in_valid && (sb.size() == 0 || out_ready);
            if (sb.size() != 0 && out_ready) void'(sb.pop_front());
            if (acc) begin
                sb.push_back('{r64: model(instr, 64), r32: model(instr, 32)});
                rst_state = 1'b0;
            end
        end
    end

    // Monitor: compares presented outputs against the head of the scoreboard.
    always @(negedge clk) begin
        logic  ev, er;
        pair_t e;
        if (started) begin
            ev = (sb.size() != 0);
            er = !ev || out_ready;
            chk("outvalid64", 64'(ov64), 64'(ev));
            chk("outvalid32", 64'(ov32), 64'(ev));
            chk("inready64", 64'(ir64), 64'(er));
            chk("inready32", 64'(ir32), 64'(er));
            if (ev) begin
                e = sb[0];
                chk("imm64", imm64, e.r64.imm);
                chk("type64", 64'(ty64), 64'(e.r64.typ));
                chk("hasimm64", 64'(hi64), 64'(e.r64.has));
                chk("illegal64", 64'(il64), 64'(e.r64.ill));
                chk("imm32", 64'(imm32), e.r32.imm);
                chk("type32", 64'(ty32), 64'(e.r32.typ));
                chk("hasimm32", 64'(hi32), 64'(e.r32.has));
                chk("illegal32", 64'(il32), 64'(e.r32.ill));
            end
            if (rst_state) begin
                chk("rst_imm64", imm64, 64'd0);
                chk("rst_type64", 64'(ty64), 64'(Imm11t0));
                chk("rst_flags64", 64'({hi64, il64}), 64'd0);
                chk("rst_imm32", 64'(imm32), 64'd0);
                chk("rst_type32", 64'(ty32), 64'(Imm11t0));
                chk("rst_flags32", 64'({hi32, il32}), 64'd0);
            end
        end
    end

    task automatic drive(input step_t s);
        @(posedge clk);
        #1;
        in_valid  = s.iv;
        instr     = s.w;
        out_ready = s.ordy;
        flush     = s.fl;
        reset     = s.rs;
    endtask

    localparam logic [31:0] ADDI  = 32'hFFF00093;
    localparam logic [31:0] SLLI  = 32'h03F09093;
    localparam logic [31:0] LUI   = 32'h800000B7;
    localparam logic [31:0] BEQ   = 32'hFE000EE3;
    localparam logic [31:0] SW    = 32'hFE20AC23;
    localparam logic [31:0] JAL   = 32'hFF5FF0EF;
    localparam logic [31:0] AUIPC = 32'h12345097;
    localparam logic [31:0] CSRWI = 32'h3000D073;

    step_t plan[$];
    logic [6:0] ops[16] = '{7'h03, 7'h67, 7'h13, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37,
                            7'h17, 7'h6F, 7'h33, 7'h3B, 7'h73, 7'h7F, 7'h0F, 7'h13};

    initial begin
        logic [31:0] r;
        logic [2:0]  f3;
        plan = '{
            '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1}, '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0},
            '{1'b1, ADDI, 1'b1, 1'b0, 1'b0}, '{1'b1, SLLI, 1'b1, 1'b0, 1'b0},
            '{1'b1, LUI, 1'b1, 1'b0, 1'b0},  '{1'b1, BEQ, 1'b1, 1'b0, 1'b0},
            '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0},
            // backpressure: hold LUI for three cycles, then consume and accept together
            '{1'b1, LUI, 1'b0, 1'b0, 1'b0},  '{1'b1, ADDI, 1'b0, 1'b0, 1'b0},
            '{1'b1, ADDI, 1'b0, 1'b0, 1'b0}, '{1'b1, ADDI, 1'b0, 1'b0, 1'b0},
            '{1'b1, ADDI, 1'b1, 1'b0, 1'b0}, '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0},
            // flush while holding, with a word offered
            '{1'b1, SW, 1'b0, 1'b0, 1'b0},   '{1'b1, JAL, 1'b0, 1'b1, 1'b0},
            '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0}, '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0},
            // reset in the middle of a stall
            '{1'b1, AUIPC, 1'b0, 1'b0, 1'b0}, '{1'b1, ADDI, 1'b0, 1'b0, 1'b0},
            '{1'b1, ADDI, 1'b0, 1'b0, 1'b1},  '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0},
            '{1'b1, 32'h0000007F, 1'b1, 1'b0, 1'b0}, '{1'b1, CSRWI, 1'b1, 1'b0, 1'b0},
            '{1'b1, 32'h002081B3, 1'b1, 1'b0, 1'b0}, '{1'b1, 32'h002081BB, 1'b1, 1'b0, 1'b0},
            '{1'b1, 32'h8000809B, 1'b1, 1'b0, 1'b0}, '{1'b1, 32'h01F0909B, 1'b1, 1'b0, 1'b0},
            '{1'b1, 32'h4030D093, 1'b1, 1'b0, 1'b0}, '{1'b1, 32'h8000A103, 1'b1, 1'b0, 1'b0},
            '{1'b1, 32'h7FF08067, 1'b1, 1'b0, 1'b0}, '{1'b1, SW, 1'b1, 1'b0, 1'b0},
            '{1'b1, JAL, 1'b1, 1'b0, 1'b0},   '{1'b1, AUIPC, 1'b1, 1'b0, 1'b0},
            '{1'b1, 32'h30002073, 1'b1, 1'b0, 1'b0}, '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0}
        };
        foreach (plan[i]) drive(plan[i]);

        for (int n = 0; n < 1500; n++) begin
            step_t s;
            r  = $urandom();
            f3 = 3'($urandom_range(0, 7));
            s.iv   = ($urandom_range(0, 9) < 7);
            s.w    = ($urandom_range(0, 6) == 0) ? r
                   : {r[31:15], f3, r[11:7], ops[$urandom_range(0, 15)]};
            s.ordy = ($urandom_range(0, 9) < 6);
            s.fl   = ($urandom_range(0, 19) == 0);
            s.rs   = ($urandom_range(0, 99) == 0);
            drive(s);
        end

        drive('{1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
        drive('{1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
